// File: rtl/bids_round_sequencer.sv
// Host-side auction round sequencer for the bid controller config port.
// Loads, locks, runs one round, captures the result and unlocks.
module bids_round_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [31:0]      cfg_x,
  input  logic [31:0]      cfg_y,
  input  logic [31:0]      cfg_z,
  input  logic [2:0]       cfg_mask,
  input  logic [3:0]       cfg_timer,
  input  logic [31:0]      cfg_cost,
  input  logic [31:0]      cfg_key,
  input  logic [7:0]       cfg_round_len,
  input  logic             ready,
  input  logic [2:0]       err,
  input  logic             roundOver,
  input  logic [31:0]      maxBid,
  input  logic [2:0]       win,
  output logic [3:0]       C_op,
  output logic [31:0]      C_data,
  output logic             C_start,
  output logic             busy,
  output logic             done,
  output logic             seq_err,
  output logic [2:0]       err_code,
  output logic [3:0]       err_step,
  output logic [2:0]       result_win,
  output logic [31:0]      result_maxbid,
  output logic [CNT_W-1:0] round_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, CFG, LOCK,
    ROUND, WAIT_OVER, UNLOCK, FINISH
  } state_t;

  state_t      state;
  logic [3:0]  step;
  logic [TW-1:0] tmo;
  logic [7:0]  len_cnt;
  logic [31:0] sh_x, sh_y, sh_z, sh_cost, sh_key;
  logic [2:0]  sh_mask;
  logic [3:0]  sh_timer;
  logic [7:0]  sh_len;
  logic [2:0]  cap_win;
  logic [31:0] cap_max;

  logic        waiting, cmd, tmo_hit, abort;
  logic [3:0]  nxt_op;
  logic [31:0] nxt_data;

  // Abort detection: a flagged command or an expired wait.
  always_comb begin
    waiting = (state == WAIT_RDY && !ready) ||
              (state == WAIT_OVER && !roundOver);
    cmd     = (state == CFG) || (state == LOCK) ||
              (state == UNLOCK);
    tmo_hit = waiting && (tmo == TMO_LAST);
    abort   = tmo_hit || (cmd && err != 3'd0);
  end

  // Next configuration command after the current CFG step.
  always_comb begin
    nxt_op   = 4'd2;
    nxt_data = sh_key;
    case (step)
      4'd1: begin nxt_op = 4'd4; nxt_data = sh_y; end
      4'd2: begin nxt_op = 4'd5; nxt_data = sh_z; end
      4'd3: begin nxt_op = 4'd6; nxt_data = {29'd0, sh_mask}; end
      4'd4: begin nxt_op = 4'd7; nxt_data = {28'd0, sh_timer}; end
      4'd5: begin nxt_op = 4'd8; nxt_data = sh_cost; end
      default: begin nxt_op = 4'd2; nxt_data = sh_key; end
    endcase
  end

  // Sequencer FSM with registered controller-facing outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      step          <= '0;
      tmo           <= '0;
      len_cnt       <= '0;
      sh_x          <= '0;
      sh_y          <= '0;
      sh_z          <= '0;
      sh_cost       <= '0;
      sh_key        <= '0;
      sh_mask       <= '0;
      sh_timer      <= '0;
      sh_len        <= '0;
      cap_win       <= '0;
      cap_max       <= '0;
      C_op          <= '0;
      C_data        <= '0;
      C_start       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      seq_err       <= 1'b0;
      err_code      <= '0;
      err_step      <= '0;
      result_win    <= '0;
      result_maxbid <= '0;
      round_count   <= '0;
    end else begin
      done <= 1'b0;
      tmo  <= waiting ? tmo + 1'b1 : '0;
      if (abort) begin
        C_op     <= '0;
        C_data   <= '0;
        C_start  <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b1;
        seq_err  <= 1'b1;
        err_code <= tmo_hit ? 3'b111 : err;
        err_step <= step;
        tmo      <= '0;
        state    <= FINISH;
      end else begin
        case (state)
          IDLE: if (go) begin
            sh_x     <= cfg_x;
            sh_y     <= cfg_y;
            sh_z     <= cfg_z;
            sh_mask  <= cfg_mask;
            sh_timer <= cfg_timer;
            sh_cost  <= cfg_cost;
            sh_key   <= cfg_key;
            sh_len   <= cfg_round_len;
            busy     <= 1'b1;
            seq_err  <= 1'b0;
            err_code <= '0;
            err_step <= '0;
            step     <= 4'd0;
            state    <= WAIT_RDY;
          end
          WAIT_RDY: if (ready) begin
            C_op   <= 4'd3;
            C_data <= sh_x;
            step   <= 4'd1;
            state  <= CFG;
          end
          CFG: begin
            C_op   <= nxt_op;
            C_data <= nxt_data;
            step   <= step + 4'd1;
            if (step == 4'd6) state <= LOCK;
          end
          LOCK: begin
            C_op    <= '0;
            C_data  <= '0;
            C_start <= 1'b1;
            len_cnt <= (sh_len == 8'd0) ? 8'd0 : sh_len - 8'd1;
            step    <= 4'd8;
            state   <= ROUND;
          end
          ROUND: begin
            if (len_cnt == 8'd0) begin
              C_start <= 1'b0;
              step    <= 4'd9;
              state   <= WAIT_OVER;
            end else begin
              len_cnt <= len_cnt - 8'd1;
            end
          end
          WAIT_OVER: if (roundOver) begin
            cap_win <= win;
            cap_max <= maxBid;
            C_op    <= 4'd1;
            C_data  <= sh_key;
            step    <= 4'd10;
            state   <= UNLOCK;
          end
          UNLOCK: begin
            C_op          <= '0;
            C_data        <= '0;
            busy          <= 1'b0;
            done          <= 1'b1;
            result_win    <= cap_win;
            result_maxbid <= cap_max;
            round_count   <= round_count + 1'b1;
            state         <= FINISH;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bids_round_sequencer.sv
// Directed bench for bids_round_sequencer with a small
// behavioural model of the bid controller side.
module tb_bids_round_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        go = 1'b0;
  logic [31:0] cfg_x = 0, cfg_y = 0, cfg_z = 0;
  logic [2:0]  cfg_mask = 0;
  logic [3:0]  cfg_timer = 0;
  logic [31:0] cfg_cost = 0, cfg_key = 0;
  logic [7:0]  cfg_round_len = 0;
  logic        ready;
  logic [2:0]  err;
  logic        roundOver;
  logic [31:0] maxBid = 0;
  logic [2:0]  win = 0;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start, busy, done, seq_err;
  logic [2:0]  err_code, err_step_lo;
  logic [3:0]  err_step;
  logic [2:0]  result_win;
  logic [31:0] result_maxbid;
  logic [15:0] round_count;

  logic        rdy_en = 1'b1;
  logic        ro_en = 1'b1;
  logic        inj_en = 1'b0;
  logic [3:0]  inj_op = 0;
  logic [2:0]  inj_val = 0;
  logic        started;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0]  ops[$];
  logic [31:0] dat[$];
  int          cyc[$];
  int          n_start, n_busy, n_done;
  logic [3:0]  done_op;
  logic        done_start;

  bids_round_sequencer dut (
    .clk(clk), .reset_n(reset_n), .go(go),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_z(cfg_z),
    .cfg_mask(cfg_mask), .cfg_timer(cfg_timer),
    .cfg_cost(cfg_cost), .cfg_key(cfg_key),
    .cfg_round_len(cfg_round_len),
    .ready(ready), .err(err), .roundOver(roundOver),
    .maxBid(maxBid), .win(win),
    .C_op(C_op), .C_data(C_data), .C_start(C_start),
    .busy(busy), .done(done), .seq_err(seq_err),
    .err_code(err_code), .err_step(err_step),
    .result_win(result_win), .result_maxbid(result_maxbid),
    .round_count(round_count)
  );

  assign err_step_lo = err_step[2:0];

  always #5 clk = ~clk;

  // Controller model: err responds to the current opcode.
  always_comb begin
    ready     = rdy_en;
    err       = (inj_en && C_op == inj_op) ? inj_val : 3'd0;
    roundOver = ro_en && started && !C_start;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) started <= 1'b0;
    else if (C_start) started <= 1'b1;
    else if (done) started <= 1'b0;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input bit extra_go, input int budget);
    int stop;
    ops.delete(); dat.delete(); cyc.delete();
    n_start = 0; n_busy = 0; n_done = 0;
    done_op = 4'hf; done_start = 1'b1;
    stop = budget;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (C_op != 4'd0) begin
        ops.push_back(C_op);
        dat.push_back(C_data);
        cyc.push_back(i);
      end
      if (C_start) n_start++;
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          done_op = C_op;
          done_start = C_start;
          stop = i + 4;
        end
      end
      if (i >= stop) break;
      go = extra_go && (i == 3);
      @(negedge clk);
    end
    go = 1'b0;
    check("run_done", n_done, 1);
  endtask

  logic [3:0]  eop[8] = '{4'd3, 4'd4, 4'd5, 4'd6,
                          4'd7, 4'd8, 4'd2, 4'd1};
  logic [31:0] edat[8] = '{32'd100, 32'd200, 32'd300, 32'd7,
                           32'd3, 32'd1, 32'hA5A5, 32'hA5A5};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_op", C_op, 0);
    check("rst_data", C_data, 0);
    check("rst_flags", {C_start, busy, done, seq_err}, 0);
    check("rst_err", {err_code, err_step}, 0);
    check("rst_res", {result_win, result_maxbid}, 0);
    check("rst_cnt", round_count, 0);
    reset_n = 1'b1;

    cfg_x = 100; cfg_y = 200; cfg_z = 300;
    cfg_mask = 3'd7; cfg_timer = 4'd3; cfg_cost = 1;
    cfg_key = 32'hA5A5; cfg_round_len = 8'd4;
    win = 3'b100; maxBid = 32'h1234;
    run(1'b0, 60);
    check("t1_nops", ops.size(), 8);
    for (int i = 0; i < 8 && i < ops.size(); i++) begin
      check($sformatf("t1_op%0d", i), ops[i], eop[i]);
      check($sformatf("t1_dat%0d", i), dat[i], edat[i]);
    end
    for (int i = 0; i < 7 && i < cyc.size(); i++)
      check($sformatf("t1_cyc%0d", i), cyc[i] - cyc[0], i);
    check("t1_start", n_start, 4);
    check("t1_cnt", round_count, 1);
    check("t1_win", result_win, 3'b100);
    check("t1_max", result_maxbid, 32'h1234);
    check("t1_err", seq_err, 0);
    check("t1_doneop", done_op, 0);

    inj_en = 1'b1; inj_op = 4'd4; inj_val = 3'b010;
    win = 3'b001; maxBid = 32'd55;
    run(1'b0, 60);
    inj_en = 1'b0;
    check("t2_nops", ops.size(), 2);
    check("t2_seqerr", seq_err, 1);
    check("t2_code", err_code, 2);
    check("t2_step", err_step, 2);
    check("t2_doneop", done_op, 0);
    check("t2_cnt", round_count, 1);
    check("t2_max", result_maxbid, 32'h1234);

    rdy_en = 1'b0;
    run(1'b0, 400);
    rdy_en = 1'b1;
    check("t3_code", err_code, 3'b111);
    check("t3_step", err_step, 0);
    check("t3_busycyc", n_busy, 255);
    check("t3_busy", busy, 0);
    check("t3_nops", ops.size(), 0);

    ro_en = 1'b0;
    run(1'b0, 400);
    ro_en = 1'b1;
    check("t4_code", err_code, 3'b111);
    check("t4_step", err_step, 9);
    check("t4_start", done_start, 0);
    check("t4_cnt", round_count, 1);
    check("t4_win", result_win, 3'b100);

    cfg_round_len = 8'd0; win = 3'b001; maxBid = 32'd99;
    run(1'b1, 60);
    check("t5_start", n_start, 1);
    check("t5_ndone", n_done, 1);
    check("t5_seqerr", seq_err, 0);
    check("t5_cnt", round_count, 2);
    check("t5_max", result_maxbid, 99);

    cfg_round_len = 8'd6;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int i = 0; i < 30 && !C_start; i++) @(negedge clk);
    check("t6_inround", C_start, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_start", C_start, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cnt", round_count, 0);
    @(negedge clk); reset_n = 1'b1;
    cfg_round_len = 8'd2;
    run(1'b0, 60);
    check("t6_nops", ops.size(), 8);
    check("t6_start", n_start, 2);
    check("t6_cnt", round_count, 1);
    check("t6_seqerr", seq_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bids_round_sequencer.md
Name: bids_round_sequencer

Overview:
Host-side controller that sequences one complete auction round on the bid controller's C_op/C_data/C_start configuration interface. It loads balances, mask, timer and bid cost, then locks with a key and holds C_start for a programmed number of cycles. It then captures the winner and maxBid, and unlocks with the same key. It replaces hand-driven testbench sequences with a single go/done handshake and reports the first error the controller flags.

Parameters:
TIMEOUT, 255, max cycles to wait for ready or roundOver before aborting
CNT_W, 16, width of the completed-round counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
go  in  1  single-cycle pulse that starts a sequence; ignored while busy
cfg_x  in  32  initial X balance
cfg_y  in  32  initial Y balance
cfg_z  in  32  initial Z balance
cfg_mask  in  3  player mask
cfg_timer  in  4  bad-key lockout timer
cfg_cost  in  32  bid charge
cfg_key  in  32  lock/unlock key
cfg_round_len  in  8  C_start high cycles (0 treated as 1)
ready  in  1  controller ready
err  in  3  controller error code (combinational response to the current C_op/C_start)
roundOver  in  1  controller round-over flag
maxBid  in  32  controller max bid
win  in  3  {X_win,Y_win,Z_win}
C_op  out  4  opcode to controller
C_data  out  32  data to controller
C_start  out  1  round start/active
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at end of a sequence (success or abort)
seq_err  out  1  sticky abort flag; cleared on next accepted go
err_code  out  3  err value captured at abort (3'b111 = timeout)
err_step  out  4  state index at abort
result_win  out  3  captured win
result_maxbid  out  32  captured maxBid
round_count  out  CNT_W  successful rounds completed, wraps

Behaviour:
- Reset: all outputs 0 (C_op = NoOperation = 0); FSM in IDLE; cfg shadow registers cleared.
- All outputs are registered. C_op/C_data/C_start change only on clk rising edges.
- On go in IDLE: latch all cfg_* into shadow registers, set busy, clear seq_err/err_code/err_step, go to WAIT_RDY.
- WAIT_RDY (step 0): C_op = 0. Wait for ready = 1, then enter CFG. If ready stays low for TIMEOUT cycles, abort with code 3'b111.
- CFG, steps 1..6: issue LoadX(3), LoadY(4), LoadZ(5), SetMask(6, data = zero-extended mask), SetTimer(7, zero-extended), BidCharge(8), each for exactly one cycle. C_data carries the matching shadow value.
- Each command cycle: sample err. Nonzero err aborts the sequence with err_code = err and err_step = step.
- LOCK (step 7): C_op = 2, C_data = key, one cycle; err checked as above.
- ROUND (step 8): C_op = 0. C_start = 1 for max(cfg_round_len, 1) cycles, counted by an 8-bit down-counter. Then C_start = 0.
- WAIT_OVER (step 9): wait for roundOver = 1, subject to TIMEOUT. On the detecting cycle, capture win and maxBid.
- UNLOCK (step 10): C_op = 1, C_data = key, one cycle. Nonzero err aborts with step 10.
- FINISH: C_op = 0, done pulse, busy = 0, round_count + 1 (modular), return to IDLE.
- Abort (any step): drive C_op = 0 and C_start = 0 next cycle. Set seq_err and pulse done. round_count is unchanged and result_* are not updated. Return to IDLE. No automatic unlock; the host re-issues go.
- go while busy is ignored. go in the same cycle as done is not accepted; it is honoured from IDLE only.
- Timeout counter reloads on every state entry and counts only in WAIT_RDY/WAIT_OVER. Abort fires on reaching TIMEOUT.
- reset_n low mid-sequence: immediate return to reset values, including C_start = 0.

Test Plan:
- Reset then go with x=100, y=200, z=300, mask=7, timer=3, cost=1, key=0xA5A5, len=4 -> C_op sequence 3,4,5,6,7,8,2 on consecutive cycles; C_start high exactly 4 cycles; unlock with 0xA5A5; done pulses; round_count=1; result_* match the model's win/maxBid.
- Model forces err=3'b010 during the LoadY cycle -> abort next cycle; seq_err=1, err_code=2, err_step=2, C_op=0, round_count unchanged.
- Hold ready=0 with TIMEOUT=255 -> done with err_code=7, err_step=0 after 255 wait cycles; busy low.
- Withhold roundOver -> timeout abort with err_step=9, C_start already 0.
- cfg_round_len=0 -> C_start high exactly 1 cycle; go pulsed while busy -> ignored, single done.
- Assert reset_n low during ROUND -> C_start and busy drop asynchronously; next go runs a full clean sequence.
